panel_write_arbiter: RTL and testbench
======================================

Name: panel_write_arbiter

Overview:
- Shares the single panel write bus (ctrl_en/ctrl_addr/ctrl_wdat) feeding the nine ledpanel instances between two write sources.
- Port s0 is the UDP panel writer; port s1 is a local source such as a test-pattern or overlay generator.
- Grants whole bursts (frame or partial frame) so one source's pixels are never interleaved with the other's.
- Recovers the bus from a stalled source with a watchdog, and counts protocol errors.

Parameters:
- NUM_PANELS, 9: number of panel enables driven; ctrl_en width.
- TIMEOUT_CYCLES, 1024: idle cycles inside a granted burst before forced release; legal range 2..65535.
- FIXED_PRIO, 0: 0 = round-robin between s0 and s1; 1 = s0 always wins when both request in IDLE.

Ports:
- clock  in  1  system clock, same domain as the UDP writer and the ledpanel ctrl side
- reset  in  1  synchronous, active-high reset
- s0_valid  in  1  s0 has a write beat
- s0_ready  out  1  s0 beat accepted when s0_valid & s0_ready
- s0_last  in  1  final beat of the s0 burst
- s0_panel  in  4  target panel 0..NUM_PANELS-1; 15 = broadcast
- s0_addr  in  16  pixel address {col,row}
- s0_wdat  in  24  pixel colour {R,G,B}
- s1_valid, s1_ready, s1_last, s1_panel, s1_addr, s1_wdat: same as s0, for s1
- ctrl_en  out  NUM_PANELS  one-cycle write strobe per panel
- ctrl_addr  out  16  write address, valid while any ctrl_en bit is high
- ctrl_wdat  out  24  write data, valid while any ctrl_en bit is high
- grant  out  2  one-hot current owner; 00 = idle
- timeout_count  out  8  saturating count of watchdog releases
- drop_count  out  8  saturating count of beats carrying an illegal panel index

Behaviour:
- Reset (synchronous, reset=1 at a clock edge): state=IDLE; ctrl_en=0; ctrl_addr=0; ctrl_wdat=0; grant=00; s0_ready=s1_ready=0; counters=0; round-robin pointer=s1, so s0 wins the first tie.
- Reset mid-burst aborts the burst immediately. No ctrl_en pulse is issued in the cycle after reset is asserted.
- States: IDLE, GNT0, GNT1.
- IDLE transitions:
  - Only s0_valid -> GNT0. Only s1_valid -> GNT1.
  - Both valid: FIXED_PRIO=1 -> GNT0; otherwise grant the source not served last.
  - Arbitration takes one cycle; no beat is accepted while in IDLE.
- sN_ready is a decode of the state register (GNT0 -> s0_ready=1, GNT1 -> s1_ready=1) and never depends combinationally on sN_valid.
- Accepted beat (valid & ready at edge T), registered outputs at T+1:
  - ctrl_addr and ctrl_wdat take the beat's values.
  - ctrl_en is one-hot bit[panel] for panel < NUM_PANELS, all ones for panel=15.
  - Any other panel value: ctrl_en=0, drop_count+1 (saturating at 255), beat still consumed.
  - ctrl_addr and ctrl_wdat hold their values when no beat is accepted.
- Latency: beat accepted at T -> strobe at T+1. Back-to-back beats give back-to-back strobes, throughput 1 beat/cycle.
- Burst end: an accepted beat with last=1 moves the state to IDLE at T+1 and updates the round-robin pointer. The next grant appears at T+2 at the earliest. There is always one IDLE cycle between bursts.
- Watchdog:
  - A 16-bit counter clears on grant entry and on every accepted beat, and increments each granted cycle with no beat.
  - When it reaches TIMEOUT_CYCLES-1 the state goes to IDLE, timeout_count increments (saturating), and the pointer updates as for a normal release.
  - If a beat is accepted in the same cycle the counter would expire, the beat wins: it is written and the counter clears.
- A source that drops valid mid-burst keeps the grant until it sends last or the watchdog expires.
- grant mirrors the state register.

Optional Feature:
- Macro PANEL_WRITE_MASK_EN adds input panel_mask [NUM_PANELS-1:0], sampled every cycle.
- With the macro: ctrl_en = decoded enable & ~panel_mask. A fully masked beat is consumed silently and drop_count is not incremented. This lets the host blank or freeze individual cube faces.
- Without the macro: the port does not exist and every decoded enable is driven.

Test Plan:
- Reset, then s0 burst of 3 beats (panel 2, addr 0x0001..0x0003, wdat 0xFF0000, last on 3rd) -> grant=01 one cycle after valid; ctrl_en=0x004 on 3 consecutive cycles with matching addr/wdat; grant=00 after the last strobe.
- s0 and s1 both valid in IDLE, FIXED_PRIO=0 -> s0 served first; s1 granted after the one IDLE cycle; next tie goes to s0 again. FIXED_PRIO=1 -> s0 wins every tie.
- s1 beat with panel=15, wdat 0x00FF00 -> ctrl_en=0x1FF for one cycle. Panel=9 -> ctrl_en=0 and drop_count increments 0->1.
- TIMEOUT_CYCLES=8: s0 sends 1 beat without last and then drops valid -> 7 granted idle cycles, then grant=00 and timeout_count=1; a waiting s1 is granted next.
- Assert reset during the 2nd beat of a 4-beat s0 burst -> grant=00, ctrl_en=0 next cycle; after release s0 re-arbitrates from IDLE.
- With PANEL_WRITE_MASK_EN and panel_mask=0x004: a broadcast beat -> ctrl_en=0x1FB; a panel-2 beat -> ctrl_en=0 with drop_count unchanged.

Source files
------------

// File: rtl/panel_write_arbiter_if.sv
// Write-source handshake bundle for panel_write_arbiter.
// One instance per source: beat payload plus valid/ready.
interface panel_write_arbiter_if;
  logic        valid;
  logic        ready;
  logic        last;
  logic [3:0]  panel;
  logic [15:0] addr;
  logic [23:0] wdat;

  modport master (
    output valid, last, panel, addr, wdat,
    input  ready
  );

  modport slave (
    input  valid, last, panel, addr, wdat,
    output ready
  );
endinterface

// File: rtl/panel_write_arbiter.sv
// Two-source burst arbiter for the shared ledpanel write bus, with watchdog.
// Optional PANEL_WRITE_MASK_EN adds a per-panel write mask input.
module panel_write_arbiter #(
  parameter int NUM_PANELS     = 9,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FIXED_PRIO     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  panel_write_arbiter_if.slave  s0,
  panel_write_arbiter_if.slave  s1,
`ifdef PANEL_WRITE_MASK_EN
  input  logic [NUM_PANELS-1:0] panel_mask,
`endif
  output logic [NUM_PANELS-1:0] ctrl_en,
  output logic [15:0]           ctrl_addr,
  output logic [23:0]           ctrl_wdat,
  output logic [1:0]            grant,
  output logic [7:0]            timeout_count,
  output logic [7:0]            drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 2);
  localparam logic [4:0]  NP      = 5'(NUM_PANELS);
  localparam logic [NUM_PANELS-1:0] ONE = {{(NUM_PANELS-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;
  logic [15:0]           wd_q, wd_d;
  logic [NUM_PANELS-1:0] en_q, en_d;
  logic [15:0]           addr_q, addr_d;
  logic [23:0]           wdat_q, wdat_d;
  logic [7:0]            tmo_q, tmo_d;
  logic [7:0]            drop_q, drop_d;

  logic                  beat;
  logic                  b_last;
  logic [3:0]            b_panel;
  logic [15:0]           b_addr;
  logic [23:0]           b_wdat;
  logic [NUM_PANELS-1:0] dec;
  logic                  illegal;
  logic [NUM_PANELS-1:0] mask;

`ifdef PANEL_WRITE_MASK_EN
  assign mask = panel_mask;
`else
  assign mask = '0;
`endif

  assign s0.ready      = (state_q == GNT0);
  assign s1.ready      = (state_q == GNT1);
  assign grant         = state_q;
  assign ctrl_en       = en_q;
  assign ctrl_addr     = addr_q;
  assign ctrl_wdat     = wdat_q;
  assign timeout_count = tmo_q;
  assign drop_count    = drop_q;

  always_comb begin
    beat    = 1'b0;
    b_last  = 1'b0;
    b_panel = 4'd0;
    b_addr  = 16'd0;
    b_wdat  = 24'd0;
    unique case (1'b1)
      (state_q == GNT0): begin
        beat    = s0.valid;
        b_last  = s0.last;
        b_panel = s0.panel;
        b_addr  = s0.addr;
        b_wdat  = s0.wdat;
      end
      (state_q == GNT1): begin
        beat    = s1.valid;
        b_last  = s1.last;
        b_panel = s1.panel;
        b_addr  = s1.addr;
        b_wdat  = s1.wdat;
      end
      default: ;
    endcase
  end

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    if (b_panel == 4'hF) begin
      dec = '1;
    end else if ({1'b0, b_panel} < NP) begin
      dec = ONE << b_panel;
    end else begin
      illegal = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    en_d    = '0;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    tmo_d   = tmo_q;
    drop_d  = drop_q;

    if (state_q == IDLE) begin
      wd_d = 16'd0;
      // rr_q high means s1 was served last, so s0 takes the tie
      if (s0.valid && s1.valid) begin
        state_d = (FIXED_PRIO != 0 || rr_q) ? GNT0 : GNT1;
      end else if (s0.valid) begin
        state_d = GNT0;
      end else if (s1.valid) begin
        state_d = GNT1;
      end
    end else if (beat) begin
      wd_d   = 16'd0;
      addr_d = b_addr;
      wdat_d = b_wdat;
      en_d   = dec & ~mask;
      if (illegal && drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
      if (b_last) begin
        state_d = IDLE;
        rr_d    = (state_q == GNT1);
      end
    end else if (wd_q == WD_LAST) begin
      state_d = IDLE;
      rr_d    = (state_q == GNT1);
      if (tmo_q != 8'hFF) begin
        tmo_d = tmo_q + 8'd1;
      end
    end else begin
      wd_d = wd_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b1;
      wd_q    <= 16'd0;
      en_q    <= '0;
      addr_q  <= 16'd0;
      wdat_q  <= 24'd0;
      tmo_q   <= 8'd0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_panel_write_arbiter.sv
// Scoreboard bench for panel_write_arbiter (round-robin, 8-cycle watchdog).
// Define PANEL_WRITE_MASK_EN to also exercise the panel mask.
module tb_panel_write_arbiter;

  logic        clock;
  logic        reset;
  logic [8:0]  ctrl_en;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic [1:0]  grant;
  logic [7:0]  timeout_count;
  logic [7:0]  drop_count;
`ifdef PANEL_WRITE_MASK_EN
  logic [8:0]  panel_mask;
`endif

  panel_write_arbiter_if s0_if ();
  panel_write_arbiter_if s1_if ();

  panel_write_arbiter #(
    .NUM_PANELS     (9),
    .TIMEOUT_CYCLES (8),
    .FIXED_PRIO     (0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .s0            (s0_if.slave),
    .s1            (s1_if.slave),
`ifdef PANEL_WRITE_MASK_EN
    .panel_mask    (panel_mask),
`endif
    .ctrl_en       (ctrl_en),
    .ctrl_addr     (ctrl_addr),
    .ctrl_wdat     (ctrl_wdat),
    .grant         (grant),
    .timeout_count (timeout_count),
    .drop_count    (drop_count)
  );

  typedef struct packed {
    logic [8:0]  en;
    logic [15:0] a;
    logic [23:0] d;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [8:0] en, input logic [15:0] a,
                      input logic [23:0] d);
    exp_t x;
    x.en = en;
    x.a  = a;
    x.d  = d;
    q.push_back(x);
  endtask

  task automatic drive(input int src, input logic v, input logic [3:0] p,
                       input logic [15:0] a, input logic [23:0] d,
                       input logic l);
    if (src == 0) begin
      s0_if.valid = v; s0_if.panel = p; s0_if.addr = a;
      s0_if.wdat  = d; s0_if.last  = l;
    end else begin
      s1_if.valid = v; s1_if.panel = p; s1_if.addr = a;
      s1_if.wdat  = d; s1_if.last  = l;
    end
  endtask

  task automatic send(input int src, input logic [3:0] p,
                      input logic [15:0] a, input logic [23:0] d,
                      input logic l);
    bit ok;
    logic rdy;
    ok = 1'b0;
    drive(src, 1'b1, p, a, d, l);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      rdy = (src == 0) ? s0_if.ready : s1_if.ready;
      if (rdy) begin
        @(posedge clock);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL handshake_wait: src %0d got no ready", src);
    end
    drive(src, 1'b0, p, a, d, 1'b0);
  endtask

  // Any strobe must match the next expected write, in order
  always @(negedge clock) begin
    if (ctrl_en != 9'd0) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL strobe_unexpected: got en 0x%0h required none",
                 ctrl_en);
      end else begin
        e = q.pop_front();
        chk("strobe_en", ctrl_en, e.en);
        chk("strobe_addr", ctrl_addr, e.a);
        chk("strobe_wdat", ctrl_wdat, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    drive(0, 1'b0, 4'd0, 16'd0, 24'd0, 1'b0);
    drive(1, 1'b0, 4'd0, 16'd0, 24'd0, 1'b0);
`ifdef PANEL_WRITE_MASK_EN
    panel_mask = 9'd0;
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_grant", grant, 2'b00);
    chk("rst_en", ctrl_en, 9'd0);
    chk("rst_addr", ctrl_addr, 16'd0);
    chk("rst_wdat", ctrl_wdat, 24'd0);
    chk("rst_ready", {s1_if.ready, s0_if.ready}, 2'b00);
    chk("rst_cnt", {timeout_count, drop_count}, 16'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // s0 3-beat burst to panel 2
    push(9'h004, 16'h0001, 24'hFF0000);
    push(9'h004, 16'h0002, 24'hFF0000);
    push(9'h004, 16'h0003, 24'hFF0000);
    fork
      begin
        send(0, 4'd2, 16'h0001, 24'hFF0000, 1'b0);
        send(0, 4'd2, 16'h0002, 24'hFF0000, 1'b0);
        send(0, 4'd2, 16'h0003, 24'hFF0000, 1'b1);
      end
      begin
        @(negedge clock);
        chk("t1_arb_cycle", grant, 2'b00);
        @(negedge clock);
        chk("t1_grant", grant, 2'b01);
      end
    join
    chk("t1_release", grant, 2'b00);

    // broadcast and illegal panel from s1
    push(9'h1FF, 16'h0010, 24'h00FF00);
    send(1, 4'd15, 16'h0010, 24'h00FF00, 1'b1);
    send(1, 4'd9, 16'h0020, 24'h123456, 1'b1);
    chk("t3_drop", drop_count, 8'd1);

    // tie after s1 served: s0 first, then s1
    push(9'h001, 16'h0100, 24'h000001);
    push(9'h001, 16'h0101, 24'h000002);
    push(9'h100, 16'h0200, 24'h000003);
    push(9'h100, 16'h0201, 24'h000004);
    fork
      begin
        send(0, 4'd0, 16'h0100, 24'h000001, 1'b0);
        send(0, 4'd0, 16'h0101, 24'h000002, 1'b1);
        chk("t4_idle_gap", grant, 2'b00);
      end
      begin
        send(1, 4'd8, 16'h0200, 24'h000003, 1'b0);
        send(1, 4'd8, 16'h0201, 24'h000004, 1'b1);
      end
    join

    // next tie goes to s0 again
    push(9'h002, 16'h0300, 24'hABCDEF);
    push(9'h080, 16'h0400, 24'h654321);
    fork
      send(0, 4'd1, 16'h0300, 24'hABCDEF, 1'b1);
      send(1, 4'd7, 16'h0400, 24'h654321, 1'b1);
    join

    // watchdog: s0 stalls after one beat, s1 waits
    push(9'h004, 16'h0040, 24'h0000AA);
    push(9'h1FF, 16'h0041, 24'h0000BB);
    send(0, 4'd2, 16'h0040, 24'h0000AA, 1'b0);
    fork
      send(1, 4'd15, 16'h0041, 24'h0000BB, 1'b1);
      begin
        n = 0;
        @(negedge clock);
        while (grant == 2'b01 && n < 30) begin
          n++;
          @(negedge clock);
        end
        chk("t6_idle_grant_cycles", n, 7);
        chk("t6_release", grant, 2'b00);
        chk("t6_tmo_count", timeout_count, 8'd1);
        @(negedge clock);
        chk("t6_s1_next", grant, 2'b10);
      end
    join
    chk("t6_s1_done", grant, 2'b00);

`ifdef PANEL_WRITE_MASK_EN
    panel_mask = 9'h004;
    push(9'h1FB, 16'h0060, 24'h111111);
    send(0, 4'd15, 16'h0060, 24'h111111, 1'b1);
    send(0, 4'd2, 16'h0061, 24'h222222, 1'b1);
    chk("t7_mask_drop", drop_count, 8'd1);
    panel_mask = 9'd0;
`endif

    // reset during 2nd beat of a 4-beat burst
    push(9'h004, 16'h0050, 24'h0F0F0F);
    send(0, 4'd2, 16'h0050, 24'h0F0F0F, 1'b0);
    drive(0, 1'b1, 4'd2, 16'h0051, 24'h0F0F0F, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("t8_grant", grant, 2'b00);
    chk("t8_en", ctrl_en, 9'd0);
    chk("t8_ready", s0_if.ready, 1'b0);
    chk("t8_cnt", {timeout_count, drop_count}, 16'd0);
    reset = 1'b0;
    push(9'h004, 16'h0051, 24'h0F0F0F);
    push(9'h004, 16'h0052, 24'h0F0F0F);
    push(9'h004, 16'h0053, 24'h0F0F0F);
    send(0, 4'd2, 16'h0051, 24'h0F0F0F, 1'b0);
    send(0, 4'd2, 16'h0052, 24'h0F0F0F, 1'b0);
    send(0, 4'd2, 16'h0053, 24'h0F0F0F, 1'b1);
    chk("t8_release", grant, 2'b00);

    repeat (3) @(negedge clock);
    chk("sb_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
